sigmoid_sched: RTL and testbench

- Round-robin scheduler that shares one 2-stage `sigmoid` pipeline between N requesters.
- Each requester submits an 8-bit x with a valid/ready handshake. The block issues at most one x per cycle into the pipeline and tracks which requester owns each in-flight op with a tag shift register.
- It steers each 16-bit result into a per-requester one-entry response buffer, drained by that requester's valid/ready handshake.
- It sits between the requester fabric and the `sigmoid` instance. The top level inverts reset for `sigmoid`.

---
 rtl/sigmoid_sched.sv | 165 ++++++++++++++++
 tb/tb_sigmoid_sched.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_sched.sv
// Round-robin front end that shares one fixed-latency sigmoid pipeline
// between N requesters. Each requester may have one op in flight. A tag
// shift register that runs alongside the sigmoid pipe records which
// requester owns each result. Results land in one-entry per-requester
// response buffers, which are drained with a valid/ready handshake.
module sigmoid_sched #(
    parameter int N   = 4,
    parameter int LAT = 2,
    parameter int IDW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N-1:0]    req_valid,
    input  logic [8*N-1:0]  req_x,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    rsp_valid,
    output logic [16*N-1:0] rsp_y,
    input  logic [N-1:0]    rsp_ready,
    output logic            sig_in_valid,
    output logic [7:0]      sig_x,
    input  logic            sig_out_valid,
    input  logic [15:0]     sig_y,
    output logic [15:0]     op_count,
    output logic            err
);

    // Width of the counter that masks error detection for the first LAT
    // cycles after reset. During that window the sigmoid may still emit
    // results for ops that the reset discarded.
    localparam int SW = $clog2(LAT + 1);

    logic [N-1:0]   busy_reg;
    logic [N-1:0]   rsp_valid_reg;
    logic [15:0]    rbuf_reg [N];
    logic [IDW-1:0] ptr_reg;
    logic [LAT-1:0] tag_v_reg;
    logic [IDW-1:0] tag_id_reg [LAT];
    logic [15:0]    op_count_reg;
    logic           err_reg;
    logic [SW-1:0]  sup_cnt_reg;

    logic [N-1:0]   elig;
    logic           grant;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand_idx;
    logic           cap;
    logic [IDW-1:0] cap_id;
    logic [N-1:0]   cap_hit;
    logic [N-1:0]   drain;
    logic           err_det;

    // A requester that is still waiting on a result, or whose result has not
    // been consumed yet, is not eligible. This enforces one op in flight.
    assign elig    = req_valid & ~busy_reg & {N{en}};
    assign cap     = tag_v_reg[LAT-1] & sig_out_valid;
    assign cap_id  = tag_id_reg[LAT-1];
    assign drain   = rsp_valid_reg & rsp_ready;
    // A result with no owner, or an owner with no result, means the pipe and
    // the tag register have lost step. Flag it unless we are still inside
    // the post-reset window.
    assign err_det = (sup_cnt_reg == '0) && (sig_out_valid != tag_v_reg[LAT-1]);

    // Round-robin pick: scan from ptr+1 and wrap, taking the first eligible requester
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        cand_idx  = '0;
        for (int k = 1; k <= N; k++) begin
            cand_idx = IDW'((int'(ptr_reg) + k) % N);
            if (!grant && elig[cand_idx]) begin
                grant     = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    // Forward the granted requester's operand straight into the sigmoid
    always_comb begin
        sig_x = 8'h00;
        if (grant) begin
            sig_x = req_x[{grant_idx, 3'b000} +: 8];
        end
    end

    assign sig_in_valid = grant;
    assign rsp_valid    = rsp_valid_reg;
    assign op_count     = op_count_reg;
    assign err          = err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_req
            assign req_ready[gi]       = grant && (grant_idx == IDW'(gi));
            assign cap_hit[gi]         = cap && (cap_id == IDW'(gi));
            assign rsp_y[16*gi +: 16]  = rbuf_reg[gi];
        end
    endgenerate

    // Tag pipe shadows the sigmoid latency; the pointer moves only on a grant
    always_ff @(posedge clk) begin
        if (rst_n) begin
            ptr_reg   <= IDW'(N - 1);
            tag_v_reg <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_id_reg[k] <= '0;
            end
        end else begin
            tag_v_reg[0]  <= grant;
            tag_id_reg[0] <= grant_idx;
            for (int k = 1; k < LAT; k++) begin
                tag_v_reg[k]  <= tag_v_reg[k-1];
                tag_id_reg[k] <= tag_id_reg[k-1];
            end
            if (grant) begin
                ptr_reg <= grant_idx;
            end
        end
    end

    // Ownership and response buffers: busy spans grant through consumption
    always_ff @(posedge clk) begin
        if (rst_n) begin
            busy_reg      <= '0;
            rsp_valid_reg <= '0;
            for (int i = 0; i < N; i++) begin
                rbuf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    busy_reg[i] <= 1'b1;
                end else if (drain[i]) begin
                    busy_reg[i] <= 1'b0;
                end
                if (cap_hit[i]) begin
                    rsp_valid_reg[i] <= 1'b1;
                    rbuf_reg[i]      <= sig_y;
                end else if (drain[i]) begin
                    rsp_valid_reg[i] <= 1'b0;
                end
            end
        end
    end

    // Completion counter, sticky error flag and the post-reset masking window
    always_ff @(posedge clk) begin
        if (rst_n) begin
            op_count_reg <= '0;
            err_reg      <= 1'b0;
            sup_cnt_reg  <= SW'(LAT);
        end else begin
            if (sup_cnt_reg != '0) begin
                sup_cnt_reg <= sup_cnt_reg - SW'(1);
            end
            if (err_det) begin
                err_reg <= 1'b1;
            end
            if (cap) begin
                op_count_reg <= op_count_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sigmoid_sched.sv
// Bench for sigmoid_sched. A behavioural sigmoid stub with LAT-cycle latency
// returns y = {x + 8'h42, x ^ 8'h20}. A scoreboard records each issue and
// checks it when the owning requester's response buffer fills.
`timescale 1ns/1ps
module tb_sigmoid_sched;

    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [N-1:0]    req_valid;
    logic [8*N-1:0]  req_x;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [16*N-1:0] rsp_y;
    logic [N-1:0]    rsp_ready;
    logic            sig_in_valid;
    logic [7:0]      sig_x;
    logic            sig_out_valid;
    logic [15:0]     sig_y;
    logic [15:0]     op_count;
    logic            err;

    logic            inj;
    logic            drop;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sigmoid_sched #(.N(N), .LAT(LAT), .IDW(IDW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .req_valid     (req_valid),
        .req_x         (req_x),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_y         (rsp_y),
        .rsp_ready     (rsp_ready),
        .sig_in_valid  (sig_in_valid),
        .sig_x         (sig_x),
        .sig_out_valid (sig_out_valid),
        .sig_y         (sig_y),
        .op_count      (op_count),
        .err           (err)
    );

    function automatic logic [15:0] model_y(input logic [7:0] x);
        logic [7:0] hi;
        hi = x + 8'h42;
        return {hi, x ^ 8'h20};
    endfunction

    // Sigmoid stub. It is not reset, so results in flight survive a scheduler reset.
    logic [LAT-1:0] stub_v = '0;
    logic [7:0]     stub_x [LAT];
    always @(posedge clk) begin
        stub_v[0] <= sig_in_valid;
        stub_x[0] <= sig_x;
        for (int k = 1; k < LAT; k++) begin
            stub_v[k] <= stub_v[k-1];
            stub_x[k] <= stub_x[k-1];
        end
    end
    assign sig_out_valid = (stub_v[LAT-1] & ~drop) | inj;
    assign sig_y         = inj ? 16'hDEAD : model_y(stub_x[LAT-1]);

    typedef struct {
        int          id;
        logic [15:0] y;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic           en;
        logic [N-1:0]   valid;
        logic [8*N-1:0] x;
        logic [N-1:0]   exp_ready;
        logic [7:0]     exp_x;
    } vec_t;
    vec_t vecs[7];

    logic [N-1:0] outstanding;
    logic [N-1:0] prev_rsp;
    int           cap_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle monitor: scoreboard push on issue, pop and compare on capture
    task automatic mon();
        sb_t e;
        if (rst_n) begin
            outstanding = '0;
            prev_rsp    = '0;
            cap_cnt     = 0;
            sb_q.delete();
        end else begin
            chk("grant_onehot", 32'($onehot0(req_ready)), 32'd1);
            chk("grant_without_valid", 32'(req_ready & ~req_valid), 32'd0);
            if (req_ready == '0) begin
                chk("idle_sig_in_valid", 32'(sig_in_valid), 32'd0);
                chk("idle_sig_x", 32'(sig_x), 32'd0);
            end
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    chk("grant_while_busy", 32'(outstanding[i]), 32'd0);
                    chk("issue_valid", 32'(sig_in_valid), 32'd1);
                    chk("issue_x", 32'(sig_x), 32'(req_x[8*i +: 8]));
                    sb_q.push_back('{i, model_y(req_x[8*i +: 8])});
                    outstanding[i] = 1'b1;
                    $display("issue id=%0d x=%h", i, req_x[8*i +: 8]);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i] && !prev_rsp[i]) begin
                    cap_cnt++;
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_rsp: got id=%0d y=%h expected none", i, rsp_y[16*i +: 16]);
                    end else begin
                        e = sb_q.pop_front();
                        chk("rsp_id", 32'(i), 32'(e.id));
                        chk("rsp_y", 32'(rsp_y[16*i +: 16]), 32'(e.y));
                        chk("op_count_track", 32'(op_count), 32'(cap_cnt));
                        $display("rsp id=%0d y=%h", i, rsp_y[16*i +: 16]);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    outstanding[i] = 1'b0;
                end
            end
            prev_rsp = rsp_valid;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        mon();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            settle();
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b1;
        en        = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        inj       = 1'b0;
        drop      = 1'b0;
        settle();
        tick();
        rst_n = 1'b0;
    endtask

    task automatic check_reset_state();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_y_lo", rsp_y[31:0], 32'd0);
        chk("rst_rsp_y_hi", rsp_y[63:32], 32'd0);
        chk("rst_sig_in_valid", 32'(sig_in_valid), 32'd0);
        chk("rst_sig_x", 32'(sig_x), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
    endtask

    logic [N-1:0] rr_exp [8];
    int           others_granted;

    initial begin
        rst_n     = 1'b1;
        en        = 1'b0;
        req_valid = '0;
        req_x     = '0;
        rsp_ready = '0;
        inj       = 1'b0;
        drop      = 1'b0;

        // {en, req_valid, req_x, expected req_ready, expected sig_x}; pointer starts at N-1
        vecs[0] = '{1'b1, 4'b0001, 32'h0000_0020, 4'b0001, 8'h20};
        vecs[1] = '{1'b1, 4'b0110, 32'h00A5_3C00, 4'b0010, 8'h3C};
        vecs[2] = '{1'b1, 4'b1000, 32'h7F00_0000, 4'b1000, 8'h7F};
        vecs[3] = '{1'b1, 4'b0000, 32'hFFFF_FFFF, 4'b0000, 8'h00};
        vecs[4] = '{1'b1, 4'b1111, 32'h4433_2211, 4'b0001, 8'h11};
        vecs[5] = '{1'b0, 4'b1111, 32'h4433_2211, 4'b0000, 8'h00};
        vecs[6] = '{1'b1, 4'b1100, 32'h80FF_0000, 4'b0100, 8'hFF};

        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        tick();
        do_reset();
        settle();
        check_reset_state();
        tick();

        // Table-driven first-issue vectors, each one from a fresh reset
        for (int v = 0; v < 7; v++) begin
            do_reset();
            en        = vecs[v].en;
            req_valid = vecs[v].valid;
            req_x     = vecs[v].x;
            rsp_ready = '1;
            settle();
            chk("vec_req_ready", 32'(req_ready), 32'(vecs[v].exp_ready));
            chk("vec_sig_in_valid", 32'(sig_in_valid), 32'(|vecs[v].exp_ready));
            chk("vec_sig_x", 32'(sig_x), 32'(vecs[v].exp_x));
            tick();
            req_valid = '0;
            idle(LAT + 2);
            settle();
            chk("vec_op_count", 32'(op_count), 32'(|vecs[v].exp_ready));
            chk("vec_rsp_drained", 32'(rsp_valid), 32'd0);
            tick();
        end

        // Single op: issue at c0, result visible at c3, held until consumed
        do_reset();
        req_x     = 32'h0000_0020;
        req_valid = 4'b0001;
        settle();
        chk("single_ready", 32'(req_ready), 32'h1);
        chk("single_sig_in_valid", 32'(sig_in_valid), 32'd1);
        chk("single_sig_x", 32'(sig_x), 32'h20);
        tick();
        req_valid = '0;
        settle();
        chk("single_c1_rsp", 32'(rsp_valid), 32'd0);
        tick();
        settle();
        chk("single_c2_rsp", 32'(rsp_valid), 32'd0);
        tick();
        settle();
        chk("single_c3_rsp", 32'(rsp_valid), 32'h1);
        chk("single_c3_y", 32'(rsp_y[15:0]), 32'h6200);
        chk("single_op_count", 32'(op_count), 32'd1);
        tick();
        settle();
        chk("single_c4_hold", 32'(rsp_valid), 32'h1);
        tick();
        rsp_ready = 4'b0001;
        settle();
        tick();
        rsp_ready = '0;
        req_valid = 4'b0001;
        settle();
        chk("single_drained", 32'(rsp_valid), 32'd0);
        chk("single_regrant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        rsp_ready = '1;
        idle(5);

        // Round robin with everyone requesting: period per requester is LAT+2
        do_reset();
        rsp_ready = '1;
        req_x     = 32'h4433_2211;
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            settle();
            chk("rr_grant", 32'(req_ready), 32'(rr_exp[c]));
            tick();
        end
        req_valid = '0;
        idle(6);

        // Backpressure on requester 1 for 10 cycles after its result lands
        do_reset();
        rsp_ready = 4'b1101;
        req_x     = 32'h4433_2211;
        req_valid = '1;
        idle(4);
        others_granted = 0;
        for (int c = 0; c < 10; c++) begin
            settle();
            chk("bp_rsp_valid1", 32'(rsp_valid[1]), 32'd1);
            chk("bp_rsp_y1", 32'(rsp_y[31:16]), 32'h6402);
            chk("bp_ready1", 32'(req_ready[1]), 32'd0);
            if ((req_ready & 4'b1101) != '0) begin
                others_granted++;
            end
            tick();
        end
        chk("bp_others_granted", 32'(others_granted != 0), 32'd1);
        rsp_ready = '1;
        req_valid = '0;
        idle(6);

        // en gating with two ops in flight
        do_reset();
        rsp_ready = '1;
        req_x     = 32'h4433_2211;
        req_valid = 4'b0011;
        settle();
        chk("en_grant0", 32'(req_ready), 32'h1);
        tick();
        settle();
        chk("en_grant1", 32'(req_ready), 32'h2);
        tick();
        en        = 1'b0;
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("en_no_grant", 32'(req_ready), 32'd0);
            tick();
        end
        settle();
        chk("en_op_count", 32'(op_count), 32'd2);
        tick();
        en        = 1'b1;
        req_valid = '0;
        idle(6);

        // Stray sig_out_valid 5 cycles after reset sets the sticky error
        do_reset();
        idle(5);
        inj = 1'b1;
        settle();
        chk("err_before", 32'(err), 32'd0);
        tick();
        inj = 1'b0;
        settle();
        chk("err_set", 32'(err), 32'd1);
        tick();
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("err_sticky", 32'(err), 32'd1);
            chk("err_no_count", 32'(op_count), 32'd0);
            tick();
        end
        do_reset();
        settle();
        check_reset_state();
        tick();

        // Missing sigmoid result for a pending tag also sets the error
        do_reset();
        rsp_ready = '1;
        req_x     = 32'h0000_0020;
        req_valid = 4'b0001;
        settle();
        tick();
        req_valid = '0;
        settle();
        tick();
        drop = 1'b1;
        settle();
        tick();
        drop = 1'b0;
        settle();
        chk("drop_err", 32'(err), 32'd1);
        chk("drop_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        req_valid = 4'b0001;
        settle();
        chk("drop_still_busy", 32'(req_ready), 32'd0);
        tick();

        // Reset while ops for requesters 2 and 3 are inside the sigmoid
        do_reset();
        rsp_ready = '1;
        req_x     = 32'hBBAA_0000;
        req_valid = 4'b1100;
        settle();
        chk("mid_grant2", 32'(req_ready), 32'h4);
        tick();
        settle();
        chk("mid_grant3", 32'(req_ready), 32'h8);
        tick();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
            chk("mid_no_err", 32'(err), 32'd0);
            chk("mid_no_count", 32'(op_count), 32'd0);
            tick();
        end
        rsp_ready = '1;
        req_valid = 4'b1100;
        settle();
        chk("mid_regrant2", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b1000;
        settle();
        chk("mid_regrant3", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        idle(6);
        settle();
        chk("mid_final_count", 32'(op_count), 32'd2);
        chk("mid_final_err", 32'(err), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
